calc_sequencer: RTL and testbench

//  Sequences the 8-bit calculator datapath: decodes keypad events and drives the ALU and input-unit controls.

---
 rtl/calc_pkg.sv | 38 +++
 rtl/calc_sequencer_key_event_buf.sv | 57 +++++
 rtl/calc_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator sequencer: FSM state encoding, key-code defaults
// and the key classifier used by the sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        OP_WAIT = 3'd1,
        ENTER_B = 3'd2,
        EXEC    = 3'd3,
        CHK     = 3'd4,
        SHOW_R  = 3'd5,
        ERROR   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        KC_NONE  = 2'd0,
        KC_DIGIT = 2'd1,
        KC_OP    = 2'd2,
        KC_EQ    = 2'd3
    } key_class_e;

    localparam logic [3:0] KEY_ADD_DEF = 4'hA;
    localparam logic [3:0] KEY_SUB_DEF = 4'hB;
    localparam logic [3:0] KEY_EQ_DEF  = 4'hE;

    function automatic key_class_e key_class(input logic [3:0] code,
                                             input logic [3:0] k_add,
                                             input logic [3:0] k_sub,
                                             input logic [3:0] k_eq);
        key_class_e kc;
        if (code <= 4'd9)                       kc = KC_DIGIT;
        else if (code == k_add || code == k_sub) kc = KC_OP;
        else if (code == k_eq)                   kc = KC_EQ;
        else                                     kc = KC_NONE;
        return kc;
    endfunction

endpackage

// File: rtl/calc_sequencer_key_event_buf.sv
// Rising-edge detectors for the clear levels plus a one-deep key buffer.
// Flush beats push/pop; a push into a full buffer that is not being popped is dropped.
module key_event_buf (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       clr_all_i,
    input  logic       clr_entry_i,
    input  logic       push_i,
    input  logic [3:0] push_code_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output logic       clr_all_rise_o,
    output logic       clr_entry_rise_o,
    output logic       buf_valid_o,
    output logic [3:0] buf_code_o
);

    logic       clr_all_q;
    logic       clr_entry_q;
    logic       valid_q, valid_d;
    logic [3:0] code_q,  code_d;

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else begin
            if (pop_i) valid_d = 1'b0;
            if (push_i && (!valid_q || pop_i)) begin
                valid_d = 1'b1;
                code_d  = push_code_i;
            end
        end
    end

    // Detectors are primed with the live levels so a level held through reset is not an edge.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            clr_all_q   <= clr_all_i;
            clr_entry_q <= clr_entry_i;
            valid_q     <= 1'b0;
            code_q      <= '0;
        end else begin
            clr_all_q   <= clr_all_i;
            clr_entry_q <= clr_entry_i;
            valid_q     <= valid_d;
            code_q      <= code_d;
        end
    end

    assign clr_all_rise_o   = clr_all_i & ~clr_all_q;
    assign clr_entry_rise_o = clr_entry_i & ~clr_entry_q;
    assign buf_valid_o      = valid_q;
    assign buf_code_o       = code_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: decodes keypad events into registered ALU/input-unit control
// pulses, with operation chaining, repeat-equals, ALU latency wait and overflow lockout.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned ALU_LAT     = 2,
    parameter logic [3:0]  KEY_ADD     = KEY_ADD_DEF,
    parameter logic [3:0]  KEY_SUB     = KEY_SUB_DEF,
    parameter logic [3:0]  KEY_EQ      = KEY_EQ_DEF,
    parameter bit          HALT_ON_OVR = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_trig,
    input  logic [3:0] key_value,
    input  logic       clr_entry,
    input  logic       clr_all,
    input  logic       ovr_in,
    output logic       load_a,
    output logic       load_b,
    output logic       load_r,
    output logic       addsub,
    output logic       a_src,
    output logic       iu_au,
    output logic       entry_clr,
    output logic       alu_clr,
    output logic       err,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int unsigned    CW       = $clog2(ALU_LAT + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(ALU_LAT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          chain_q, chain_d;
    logic          pend_q, pend_d;
    logic          load_a_q, load_a_d, load_b_q, load_b_d, load_r_q, load_r_d;
    logic          addsub_q, addsub_d, a_src_q, a_src_d, iu_au_q, iu_au_d;
    logic          entry_clr_q, entry_clr_d, alu_clr_q, alu_clr_d;
    logic          err_q, err_d, busy_q, busy_d;

    logic          clr_all_rise, clr_entry_rise, clr_any;
    logic          buf_valid;
    logic [3:0]    buf_code;
    logic          busy_st, take, kt_ok, push, pop, flush;
    logic          ev_valid;
    logic [3:0]    ev_code;
    key_class_e    ev_class;
    logic          ev_is_sub;

    key_event_buf u_kbuf (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .clr_all_i        (clr_all),
        .clr_entry_i      (clr_entry),
        .push_i           (push),
        .push_code_i      (key_value),
        .pop_i            (pop),
        .flush_i          (flush),
        .clr_all_rise_o   (clr_all_rise),
        .clr_entry_rise_o (clr_entry_rise),
        .buf_valid_o      (buf_valid),
        .buf_code_o       (buf_code)
    );

    // A buffered key outranks a fresh one; the fresh key then takes its buffer slot.
    always_comb begin
        busy_st   = (state_q == EXEC) || (state_q == CHK);
        clr_any   = clr_all_rise || clr_entry_rise;
        kt_ok     = key_trig && (key_class(key_value, KEY_ADD, KEY_SUB, KEY_EQ) != KC_NONE);
        take      = !busy_st && (state_q != ERROR) && !clr_any;
        push      = kt_ok && !clr_any && (busy_st || (take && buf_valid));
        pop       = take && buf_valid;
        flush     = clr_any || (state_q == ERROR);
        ev_valid  = take && (buf_valid || kt_ok);
        ev_code   = buf_valid ? buf_code : key_value;
        ev_class  = ev_valid ? key_class(ev_code, KEY_ADD, KEY_SUB, KEY_EQ) : KC_NONE;
        ev_is_sub = (ev_code == KEY_SUB);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chain_d     = chain_q;
        pend_d      = pend_q;
        load_a_d    = 1'b0;
        load_b_d    = 1'b0;
        load_r_d    = 1'b0;
        entry_clr_d = 1'b0;
        alu_clr_d   = 1'b0;
        addsub_d    = addsub_q;
        a_src_d     = a_src_q;
        iu_au_d     = iu_au_q;
        err_d       = err_q;

        if (clr_all_rise) begin
            entry_clr_d = 1'b1;
            alu_clr_d   = 1'b1;
            err_d       = 1'b0;
            iu_au_d     = 1'b0;
            addsub_d    = 1'b0;
            a_src_d     = 1'b0;
            chain_d     = 1'b0;
            state_d     = ENTER_A;
        end else if (clr_entry_rise && !busy_st && state_q != ERROR) begin
            entry_clr_d = 1'b1;
            if (state_q == ENTER_B) begin
                state_d = OP_WAIT;
            end else if (state_q == SHOW_R) begin
                iu_au_d = 1'b0;
                state_d = ENTER_A;
            end
        end else begin
            case (state_q)
                ENTER_A: if (ev_class == KC_OP) begin
                    load_a_d    = 1'b1;
                    a_src_d     = 1'b0;
                    addsub_d    = ev_is_sub;
                    entry_clr_d = 1'b1;
                    state_d     = OP_WAIT;
                end
                OP_WAIT: begin
                    if (ev_class == KC_DIGIT) begin
                        iu_au_d = 1'b0;
                        state_d = ENTER_B;
                    end else if (ev_class == KC_OP) begin
                        addsub_d = ev_is_sub;
                    end
                end
                ENTER_B: if (ev_class == KC_OP || ev_class == KC_EQ) begin
                    load_b_d = 1'b1;
                    chain_d  = (ev_class == KC_OP);
                    if (ev_class == KC_OP) pend_d = ev_is_sub;
                    cnt_d    = CNT_INIT;
                    state_d  = EXEC;
                end
                // load_r goes out once the count expires; CHK follows so ovr_in is valid there.
                EXEC: begin
                    if (cnt_q != '0)    cnt_d    = cnt_q - 1'b1;
                    else if (!load_r_q) load_r_d = 1'b1;
                    else                state_d  = CHK;
                end
                CHK: begin
                    iu_au_d = 1'b1;
                    if (ovr_in && HALT_ON_OVR) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else if (chain_q) begin
                        load_a_d    = 1'b1;
                        a_src_d     = 1'b1;
                        addsub_d    = pend_q;
                        entry_clr_d = 1'b1;
                        state_d     = OP_WAIT;
                    end else begin
                        state_d = SHOW_R;
                    end
                end
                SHOW_R: begin
                    if (ev_class == KC_DIGIT) begin
                        iu_au_d = 1'b0;
                        state_d = ENTER_A;
                    end else if (ev_class == KC_OP) begin
                        load_a_d    = 1'b1;
                        a_src_d     = 1'b1;
                        addsub_d    = ev_is_sub;
                        entry_clr_d = 1'b1;
                        state_d     = OP_WAIT;
                    end else if (ev_class == KC_EQ) begin
                        load_a_d = 1'b1;
                        a_src_d  = 1'b1;
                        chain_d  = 1'b0;
                        cnt_d    = CNT_INIT;
                        state_d  = EXEC;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == EXEC) || (state_d == CHK);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ENTER_A;
            cnt_q       <= '0;
            chain_q     <= 1'b0;
            pend_q      <= 1'b0;
            load_a_q    <= 1'b0;
            load_b_q    <= 1'b0;
            load_r_q    <= 1'b0;
            addsub_q    <= 1'b0;
            a_src_q     <= 1'b0;
            iu_au_q     <= 1'b0;
            entry_clr_q <= 1'b0;
            alu_clr_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chain_q     <= chain_d;
            pend_q      <= pend_d;
            load_a_q    <= load_a_d;
            load_b_q    <= load_b_d;
            load_r_q    <= load_r_d;
            addsub_q    <= addsub_d;
            a_src_q     <= a_src_d;
            iu_au_q     <= iu_au_d;
            entry_clr_q <= entry_clr_d;
            alu_clr_q   <= alu_clr_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign load_a    = load_a_q;
    assign load_b    = load_b_q;
    assign load_r    = load_r_q;
    assign addsub    = addsub_q;
    assign a_src     = a_src_q;
    assign iu_au     = iu_au_q;
    assign entry_clr = entry_clr_q;
    assign alu_clr   = alu_clr_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: expected ALU control pulses are queued as keys
// are driven and popped as the pulses appear; state and flags checked at key points.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int unsigned LAT = 2;

    logic       clk = 1'b0;
    logic       reset_n, key_trig, clr_entry, clr_all, ovr_in;
    logic [3:0] key_value;
    logic       load_a, load_b, load_r, addsub, a_src, iu_au, entry_clr, alu_clr, err, busy;
    logic [2:0] state_dbg;

    calc_sequencer #(.ALU_LAT(LAT), .HALT_ON_OVR(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .key_trig(key_trig), .key_value(key_value),
        .clr_entry(clr_entry), .clr_all(clr_all), .ovr_in(ovr_in),
        .load_a(load_a), .load_b(load_b), .load_r(load_r), .addsub(addsub), .a_src(a_src),
        .iu_au(iu_au), .entry_clr(entry_clr), .alu_clr(alu_clr), .err(err), .busy(busy),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef enum int {K_LA, K_LB, K_LR, K_CLR} kind_e;
    typedef struct { kind_e kind; logic addsub; logic a_src; } sb_t;
    sb_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cycle_no = 0, last_ld = 0;
    int n_lb = 0, n_lr = 0, n_ec = 0;
    logic ovr_arm = 1'b0, ovr_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input kind_e k, input logic as, input logic src);
        sb_t e;
        e.kind = k; e.addsub = as; e.a_src = src;
        sbq.push_back(e);
    endtask

    task automatic sb_take(input kind_e k);
        sb_t e;
        checks++;
        assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected observed=%0d expected=none", k);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_kind", 32'(k), 32'(e.kind));
            chk("sb_addsub", 32'(addsub), 32'(e.addsub));
            if (k == K_LA) chk("sb_asrc", 32'(a_src), 32'(e.a_src));
        end
    endtask

    task automatic observe();
        cycle_no++;
        if (load_a) begin last_ld = cycle_no; sb_take(K_LA); end
        if (load_b) begin last_ld = cycle_no; n_lb++; sb_take(K_LB); end
        if (load_r) begin
            n_lr++;
            chk("latency", 32'(cycle_no - last_ld), 32'(LAT));
            sb_take(K_LR);
            if (ovr_arm) ovr_pend = 1'b1;
        end
        if (alu_clr) sb_take(K_CLR);
        if (entry_clr) n_ec++;
    endtask

    // ovr_in models the ALU flag: valid the cycle after load_r.
    task automatic cyc();
        @(posedge clk);
        #1;
        ovr_in   = ovr_pend;
        ovr_pend = 1'b0;
        observe();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic key(input logic [3:0] code);
        key_trig = 1'b1; key_value = code;
        cyc();
        key_trig = 1'b0;
    endtask

    task automatic wait_state(input state_e s, input int budget, input string tag);
        for (int i = 0; i < budget && state_dbg != s; i++) cyc();
        chk(tag, 32'(state_dbg), 32'(s));
    endtask

    int ec0, lb0, lr0;

    initial begin
        reset_n = 1'b0; key_trig = 1'b0; key_value = '0;
        clr_entry = 1'b0; clr_all = 1'b0; ovr_in = 1'b0;
        idle(2);
        chk("reset_outputs", 32'({load_a, load_b, load_r, addsub, a_src, iu_au, entry_clr,
                                  alu_clr, err, busy, state_dbg}), 32'(0));
        reset_n = 1'b1;
        idle(1);

        // 12+5=
        key(4'd1); key(4'd2);
        expect_ev(K_LA, 1'b0, 1'b0);
        key(4'hA);
        chk("t1_opwait", 32'(state_dbg), 32'(OP_WAIT));
        key(4'd5);
        chk("t1_enter_b", 32'(state_dbg), 32'(ENTER_B));
        expect_ev(K_LB, 1'b0, 1'b0); expect_ev(K_LR, 1'b0, 1'b0);
        key(4'hE);
        chk("t1_busy", 32'(busy), 32'(1));
        wait_state(SHOW_R, 12, "t1_show");
        chk("t1_iu_au", 32'(iu_au), 32'(1));
        chk("t1_addsub", 32'(addsub), 32'(0));

        // repeat-equals twice, no new load_b
        lb0 = n_lb;
        for (int r = 0; r < 2; r++) begin
            expect_ev(K_LA, 1'b0, 1'b1); expect_ev(K_LR, 1'b0, 1'b0);
            key(4'hE);
            wait_state(SHOW_R, 12, "t3_show");
        end
        chk("t3_no_load_b", 32'(n_lb), 32'(lb0));

        // 12+5-3= chained
        expect_ev(K_CLR, 1'b0, 1'b0);
        clr_all = 1'b1; cyc(); clr_all = 1'b0;
        chk("t2_cleared", 32'(state_dbg), 32'(ENTER_A));
        lr0 = n_lr;
        key(4'd1); key(4'd2);
        expect_ev(K_LA, 1'b0, 1'b0);
        key(4'hA); key(4'd5);
        expect_ev(K_LB, 1'b0, 1'b0); expect_ev(K_LR, 1'b0, 1'b0); expect_ev(K_LA, 1'b1, 1'b1);
        key(4'hB);
        wait_state(OP_WAIT, 12, "t2_chain_opwait");
        chk("t2_addsub_sub", 32'(addsub), 32'(1));
        key(4'd3);
        expect_ev(K_LB, 1'b1, 1'b0); expect_ev(K_LR, 1'b1, 1'b0);
        key(4'hE);
        wait_state(SHOW_R, 12, "t2_show");
        chk("t2_load_r_count", 32'(n_lr - lr0), 32'(2));

        // E buffered during EXEC, following A dropped
        expect_ev(K_LA, 1'b1, 1'b1); expect_ev(K_LR, 1'b1, 1'b0);
        expect_ev(K_LA, 1'b1, 1'b1); expect_ev(K_LR, 1'b1, 1'b0);
        key(4'hE); key(4'hE); key(4'hA);
        idle(12);
        chk("t4_state", 32'(state_dbg), 32'(SHOW_R));
        chk("t4_addsub", 32'(addsub), 32'(1));
        chk("t4_sb_drained", 32'(sbq.size()), 32'(0));

        // overflow lockout
        expect_ev(K_LA, 1'b0, 1'b1);
        key(4'hA); key(4'd7);
        ovr_arm = 1'b1;
        expect_ev(K_LB, 1'b0, 1'b0); expect_ev(K_LR, 1'b0, 1'b0);
        key(4'hE);
        wait_state(ERROR, 12, "t5_error");
        ovr_arm = 1'b0;
        chk("t5_err", 32'(err), 32'(1));
        chk("t5_iu_au", 32'(iu_au), 32'(1));
        ec0 = n_ec;
        key(4'd3); key(4'hA); key(4'hE);
        clr_entry = 1'b1; cyc(); clr_entry = 1'b0; cyc();
        chk("t5_locked", 32'(state_dbg), 32'(ERROR));
        chk("t5_no_entry_clr", 32'(n_ec), 32'(ec0));
        expect_ev(K_CLR, 1'b0, 1'b0);
        clr_all = 1'b1; cyc();
        chk("t5_err_clear", 32'(err), 32'(0));
        chk("t5_enter_a", 32'(state_dbg), 32'(ENTER_A));
        chk("t5_iu_au_clear", 32'(iu_au), 32'(0));
        clr_all = 1'b0; cyc();

        // clr_all wins over a same-cycle key
        expect_ev(K_CLR, 1'b0, 1'b0);
        clr_all = 1'b1; key_trig = 1'b1; key_value = 4'hA;
        cyc();
        clr_all = 1'b0; key_trig = 1'b0;
        idle(2);
        chk("t6_clr_priority", 32'(state_dbg), 32'(ENTER_A));

        // clr_entry held 5 cycles in ENTER_B
        key(4'd4);
        expect_ev(K_LA, 1'b0, 1'b0);
        key(4'hA); key(4'd6);
        chk("t6_enter_b", 32'(state_dbg), 32'(ENTER_B));
        ec0 = n_ec;
        clr_entry = 1'b1; idle(5); clr_entry = 1'b0; cyc();
        chk("t6_one_entry_clr", 32'(n_ec - ec0), 32'(1));
        chk("t6_opwait", 32'(state_dbg), 32'(OP_WAIT));

        // reset mid-EXEC aborts the operation
        key(4'd2);
        expect_ev(K_LB, 1'b0, 1'b0);
        key(4'hE);
        chk("t6_exec", 32'(state_dbg), 32'(EXEC));
        lr0 = n_lr;
        reset_n = 1'b0; idle(2);
        chk("t6_reset_outputs", 32'({load_a, load_b, load_r, addsub, a_src, iu_au, entry_clr,
                                     alu_clr, err, busy, state_dbg}), 32'(0));
        reset_n = 1'b1; idle(6);
        chk("t6_no_load_r", 32'(n_lr), 32'(lr0));
        chk("t6_state", 32'(state_dbg), 32'(ENTER_A));
        chk("sb_drain", 32'(sbq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
